// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32IM instruction-fetch stage with a single outstanding imem request.
// Execute-stage redirects retarget the PC and kill any fetch already in flight.
module if_fetch_unit #(
  parameter int              Size     = 32,
  parameter logic [Size-1:0] Reset_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Branch_taken,
  input  logic [Size-1:0] Branch_target,
  input  logic            Stall,
  output logic            imem_req,
  output logic [Size-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            IF_valid,
  output logic [31:0]     IF_Instr,
  output logic [Size-1:0] IF_PC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [Size-1:0] ALIGN_MASK = ~Size'(3);
  localparam logic [Size-1:0] PC_STEP    = Size'(4);
  localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;

  state_t          state_reg, state_next;
  logic [Size-1:0] pc_reg, pc_next;
  logic [Size-1:0] inflight_pc_reg, inflight_pc_next;
  logic            kill_reg, kill_next;
  logic            valid_reg, valid_next;
  logic [31:0]     instr_reg, instr_next;
  logic [Size-1:0] if_pc_reg, if_pc_next;

  logic slot_free;
  logic accept;

  // A new fetch may only launch when its result has somewhere to land.
  assign slot_free = !valid_reg || !Stall;
  assign imem_req  = (state_reg == REQ) && slot_free;
  assign imem_addr = pc_reg & ALIGN_MASK;
  assign accept    = imem_req && imem_ready;

  assign IF_valid  = valid_reg;
  assign IF_Instr  = instr_reg;
  assign IF_PC     = if_pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= Reset_PC & ALIGN_MASK;
      inflight_pc_reg <= '0;
      kill_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      instr_reg       <= NOP_INSTR;
      if_pc_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      inflight_pc_reg <= inflight_pc_next;
      kill_reg        <= kill_next;
      valid_reg       <= valid_next;
      instr_reg       <= instr_next;
      if_pc_reg       <= if_pc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    inflight_pc_next = inflight_pc_reg;
    kill_next        = kill_reg;
    valid_next       = valid_reg;
    instr_next       = instr_reg;
    if_pc_next       = if_pc_reg;

    // Decode consumed the slot this cycle.
    if (valid_reg && !Stall) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (accept) begin
          inflight_pc_next = pc_reg;
          pc_next          = pc_reg + PC_STEP;
          state_next       = WAIT;
          if (Branch_taken) begin
            kill_next = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_next  = 1'b0;
          state_next = REQ;
          // Stale data (killed earlier or redirected right now) never reaches the slot.
          if (!kill_reg && !Branch_taken) begin
            valid_next = 1'b1;
            instr_next = imem_rdata;
            if_pc_next = inflight_pc_reg;
          end
        end else if (Branch_taken) begin
          kill_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Redirect overrides sequential PC update and any stall hold on the slot.
    if (Branch_taken) begin
      pc_next    = Branch_target & ALIGN_MASK;
      valid_next = 1'b0;
    end
  end

endmodule
